// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf
//   Two-entry in-order skid buffer that sits between two pipeline stages.
//   Each entry carries {instr, pc, exc, bd}. A flush discards everything
//   and leaves a single handler bubble (instr=0, pc=HANDLER_PC, exc=0,
//   bd=0) at the head. It also counts the cycles in which downstream
//   stalls a valid head entry.
//
// Ports
//   clk        : sole clock, rising edge
//   reset      : asynchronous, active-high reset
//   flush      : exception request; drop contents, insert handler bubble
//   in_valid   : upstream offers an entry
//   in_ready   : buffer can take an entry (registered state only)
//   in_instr   : upstream instruction payload
//   in_pc      : upstream PC
//   in_exc     : upstream exception code
//   in_bd      : upstream branch-delay flag
//   out_valid  : head entry is valid
//   out_ready  : downstream accepts the head entry (0 = stall)
//   out_instr  : head entry instruction (0 when out_valid=0)
//   out_pc     : head entry PC (0 when out_valid=0)
//   out_exc    : head entry exception code (0 when out_valid=0)
//   out_bd     : head entry branch-delay flag (0 when out_valid=0)
//   count      : number of occupied entries, 0..2
//   stall_cnt  : saturating count of cycles with out_valid & !out_ready

module pipe_stage_buf #(
  parameter int unsigned          DATA_W     = 32,
  parameter int unsigned          PC_W       = 32,
  parameter int unsigned          EXC_W      = 5,
  parameter logic [PC_W-1:0]      HANDLER_PC = 32'h0000_4180
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_instr,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [EXC_W-1:0]  in_exc,
  input  logic              in_bd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [PC_W-1:0]   out_pc,
  output logic [EXC_W-1:0]  out_exc,
  output logic              out_bd,
  output logic [1:0]        count,
  output logic [15:0]       stall_cnt
);

  localparam int unsigned ENTRY_W = DATA_W + PC_W + EXC_W + 1;

  // Entry 0 is always the head; entry 1 only holds data when count=2.
  logic [ENTRY_W-1:0] entry0_q, entry0_d;
  logic [ENTRY_W-1:0] entry1_q, entry1_d;
  logic [1:0]         count_q, count_d;
  logic [15:0]        stall_cnt_q, stall_cnt_d;

  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] in_entry;
  logic [ENTRY_W-1:0] bubble_entry;

  assign in_entry     = {in_instr, in_pc, in_exc, in_bd};
  assign bubble_entry = {{DATA_W{1'b0}}, HANDLER_PC, {EXC_W{1'b0}}, 1'b0};

  // Handshake flags depend only on registered occupancy, so there is no
  // combinational path from out_ready to in_ready.
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);

  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  // Next-state for the entry storage. Flush wins over everything. A pop
  // always shifts entry 1 into the head; a push lands in the first free
  // slot after that shift, which keeps FIFO order on simultaneous
  // push/pop. Vacated slots are zeroed so stale data never lingers.
  always_comb begin
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    count_d  = count_q;

    if (flush) begin
      entry0_d = bubble_entry;
      entry1_d = '0;
      count_d  = 2'd1;
    end else begin
      case ({push, pop})
        2'b11: begin
          // push implies count<2 and pop implies count>0, so count=1 here
          entry0_d = in_entry;
          entry1_d = '0;
        end
        2'b01: begin
          entry0_d = entry1_q;
          entry1_d = '0;
          count_d  = count_q - 2'd1;
        end
        2'b10: begin
          if (count_q == 2'd0) begin
            entry0_d = in_entry;
          end else begin
            entry1_d = in_entry;
          end
          count_d = count_q + 2'd1;
        end
        default: begin
          count_d = count_q;
        end
      endcase
    end
  end

  // Stall counter saturates rather than wrapping; only reset clears it.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entry0_q    <= '0;
      entry1_q    <= '0;
      count_q     <= 2'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      entry0_q    <= entry0_d;
      entry1_q    <= entry1_d;
      count_q     <= count_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Payload outputs are forced to zero whenever the head is not valid.
  always_comb begin
    out_instr = '0;
    out_pc    = '0;
    out_exc   = '0;
    out_bd    = 1'b0;
    if (out_valid) begin
      {out_instr, out_pc, out_exc, out_bd} = entry0_q;
    end
  end

  assign count     = count_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf
//   Directed testbench for pipe_stage_buf. Inputs change 1 time unit after
//   each rising edge and outputs are checked at that same point, so every
//   check sees the state produced by the edge just taken.

module tb_pipe_stage_buf;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [4:0]  in_exc;
  logic        in_bd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [4:0]  out_exc;
  logic        out_bd;
  logic [1:0]  count;
  logic [15:0] stall_cnt;

  int assertCount = 0;
  int failCount   = 0;

  pipe_stage_buf dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .in_exc    (in_exc),
    .in_bd     (in_bd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .out_exc   (out_exc),
    .out_bd    (out_bd),
    .count     (count),
    .stall_cnt (stall_cnt)
  );

  // 10-unit clock period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Sets the upstream side for the next edge
  task automatic applyStimulus(input logic v, input logic [31:0] instr,
                               input logic [31:0] pc, input logic [4:0] exc,
                               input logic bd, input logic rdy, input logic fl);
    in_valid  = v;
    in_instr  = instr;
    in_pc     = pc;
    in_exc    = exc;
    in_bd     = bd;
    out_ready = rdy;
    flush     = fl;
  endtask

  // Advance one rising edge, then settle
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0, 5'h0, 1'b0, 1'b0, 1'b1);
    #12;

    // Outputs during reset, even with flush asserted
    checkOutput("rst_count",     count,     0);
    checkOutput("rst_in_ready",  in_ready,  1);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_stall",     stall_cnt, 0);
    checkOutput("rst_out_pc",    out_pc,    0);

    // Release reset between edges; first push on the very next edge
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b1, 32'h2402_0001, 32'h0000_3000, 5'h0, 1'b0, 1'b1, 1'b0);
    stepCycle();
    checkOutput("lat_out_valid", out_valid, 1);
    checkOutput("lat_out_pc",    out_pc,    32'h3000);
    checkOutput("lat_out_instr", out_instr, 32'h2402_0001);
    checkOutput("lat_count",     count,     1);

    applyStimulus(1'b0, 32'h0, 32'h0, 5'h0, 1'b0, 1'b1, 1'b0);
    stepCycle();
    checkOutput("drain_count",     count,     0);
    checkOutput("drain_out_valid", out_valid, 0);
    checkOutput("drain_out_pc",    out_pc,    0);
    checkOutput("drain_out_instr", out_instr, 0);
    checkOutput("drain_stall",     stall_cnt, 0);

    // Stalled fill: A then B, then C offered while full
    applyStimulus(1'b1, 32'h0000_0011, 32'h0000_3000, 5'h3, 1'b1, 1'b0, 1'b0);
    stepCycle();
    checkOutput("fillA_count", count,     1);
    checkOutput("fillA_stall", stall_cnt, 0);

    applyStimulus(1'b1, 32'h0000_0022, 32'h0000_3004, 5'h0, 1'b0, 1'b0, 1'b0);
    stepCycle();
    checkOutput("fillB_count",    count,     2);
    checkOutput("fillB_in_ready", in_ready,  0);
    checkOutput("fillB_stall",    stall_cnt, 1);

    applyStimulus(1'b1, 32'h0000_0033, 32'h0000_3008, 5'h0, 1'b0, 1'b0, 1'b0);
    stepCycle();
    checkOutput("fullC_count",  count,     2);
    checkOutput("fullC_stall",  stall_cnt, 2);
    checkOutput("fullC_out_pc", out_pc,    32'h3000);
    checkOutput("fullC_exc",    out_exc,   5'h3);
    checkOutput("fullC_bd",     out_bd,    1);
    stepCycle();
    checkOutput("fullC2_stall", stall_cnt, 3);

    // One-cycle pop from full: A leaves, B is head
    applyStimulus(1'b0, 32'h0, 32'h0, 5'h0, 1'b0, 1'b1, 1'b0);
    stepCycle();
    checkOutput("pop_count",    count,     1);
    checkOutput("pop_in_ready", in_ready,  1);
    checkOutput("pop_out_pc",   out_pc,    32'h3004);
    checkOutput("pop_instr",    out_instr, 32'h22);
    checkOutput("pop_stall",    stall_cnt, 3);

    // Simultaneous push/pop at count 1: new entry becomes head
    applyStimulus(1'b1, 32'h0000_0044, 32'h0000_300C, 5'h1, 1'b0, 1'b1, 1'b0);
    stepCycle();
    checkOutput("pp_count",  count,  1);
    checkOutput("pp_out_pc", out_pc, 32'h300C);
    checkOutput("pp_exc",    out_exc, 5'h1);

    // Sustained streaming, one per cycle
    applyStimulus(1'b1, 32'h0000_0055, 32'h0000_3010, 5'h0, 1'b0, 1'b1, 1'b0);
    stepCycle();
    checkOutput("stream_count",  count,  1);
    checkOutput("stream_out_pc", out_pc, 32'h3010);

    // Fill to 2 under stall, then flush with input offered
    applyStimulus(1'b1, 32'h0000_0066, 32'h0000_3014, 5'h0, 1'b1, 1'b0, 1'b0);
    stepCycle();
    checkOutput("pref_count", count,     2);
    checkOutput("pref_stall", stall_cnt, 4);

    applyStimulus(1'b1, 32'h0000_0077, 32'h0000_3018, 5'h2, 1'b1, 1'b0, 1'b1);
    stepCycle();
    checkOutput("flush_count", count,     1);
    checkOutput("flush_instr", out_instr, 0);
    checkOutput("flush_pc",    out_pc,    32'h0000_4180);
    checkOutput("flush_exc",   out_exc,   0);
    checkOutput("flush_bd",    out_bd,    0);
    checkOutput("flush_stall", stall_cnt, 5);

    // Flush held: still a single bubble
    stepCycle();
    checkOutput("flush2_count", count,     1);
    checkOutput("flush2_pc",    out_pc,    32'h0000_4180);
    checkOutput("flush2_stall", stall_cnt, 6);

    // Back to count=2 with stall_cnt=7, then async reset mid-cycle
    applyStimulus(1'b1, 32'h0000_0088, 32'h0000_301C, 5'h0, 1'b0, 1'b0, 1'b0);
    stepCycle();
    checkOutput("prerst_count", count,     2);
    checkOutput("prerst_stall", stall_cnt, 7);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("arst_count",     count,     0);
    checkOutput("arst_stall",     stall_cnt, 0);
    checkOutput("arst_out_valid", out_valid, 0);
    checkOutput("arst_in_ready",  in_ready,  1);
    checkOutput("arst_out_pc",    out_pc,    0);
    @(negedge clk);
    reset = 1'b0;

    // Saturation: one entry held under a long stall
    applyStimulus(1'b1, 32'h0000_0099, 32'h0000_3020, 5'h0, 1'b0, 1'b0, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 32'h0, 32'h0, 5'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("sat_start", stall_cnt, 0);
    repeat (65534) stepCycle();
    checkOutput("sat_fffe", stall_cnt, 16'hFFFE);
    stepCycle();
    checkOutput("sat_ffff", stall_cnt, 16'hFFFF);
    repeat (5) stepCycle();
    checkOutput("sat_hold",  stall_cnt, 16'hFFFF);
    checkOutput("sat_count", count,     1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 SHALL have parameter DATA_W, default 32, instruction payload width.
REQ-002 SHALL have parameter PC_W, default 32, PC field width.
REQ-003 SHALL have parameter EXC_W, default 5, exception-code field width.
REQ-004 SHALL have parameter HANDLER_PC, default 32'h0000_4180, PC loaded on flush.
REQ-005 SHALL have port clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port flush  in  1  exception request; discard contents, insert handler bubble.
REQ-008 SHALL have ports in_valid in 1 and in_ready out 1, the upstream handshake.
REQ-009 SHALL have ports in_instr in DATA_W, in_pc in PC_W, in_exc in EXC_W and in_bd in 1, the upstream payload.
REQ-010 SHALL have ports out_valid out 1 and out_ready in 1, the downstream handshake; out_ready=0 means stall/busy.
REQ-011 SHALL have ports out_instr out DATA_W, out_pc out PC_W, out_exc out EXC_W and out_bd out 1, the head-entry payload.
REQ-012 SHALL have port count  out 2  number of occupied entries, 0..2.
REQ-013 SHALL have port stall_cnt  out 16  number of cycles with out_valid=1 and out_ready=0.

Function
REQ-014 SHALL hold a 2-entry in-order skid buffer; each entry is {instr, pc, exc, bd}.
REQ-015 SHALL drive in_ready = (count != 2), from registered state only, with no combinational path from out_ready.
REQ-016 SHALL push an entry on a rising edge when in_valid & in_ready & !flush.
REQ-017 SHALL pop the head entry on a rising edge when out_valid & out_ready & !flush.
REQ-018 SHALL drive out_valid = (count != 0).
REQ-019 SHALL drive out_* from the head entry when out_valid=1, and all zero when out_valid=0.
REQ-020 SHALL, on simultaneous push and pop, leave count unchanged and preserve FIFO order; at count 1 the new entry becomes head next cycle.
REQ-021 SHALL give a latency of 1 cycle from input acceptance into an empty buffer to out_valid=1.
REQ-022 SHALL have no data-dependent bubbles: with out_ready held at 1, one transfer is sustained per cycle.
REQ-023 SHALL, when count=2 and a pop occurs, give count=1 and in_ready=1 in the next cycle.
REQ-024 SHALL give flush priority over push and pop: next state is count=1, head = {0, HANDLER_PC, 0, 0}, and the input offered in the flush cycle is dropped.
REQ-025 SHALL, on flush held for consecutive cycles, keep re-inserting the single handler bubble (count stays 1).
REQ-026 SHALL increment stall_cnt on each rising edge with out_valid & !out_ready, saturating at 16'hFFFF, and clear it only on reset.
REQ-027 SHALL never let count exceed 2 or underflow below 0 under any input combination.

Reset
REQ-028 SHALL, on reset assertion, immediately and asynchronously set count=0, stall_cnt=0, all entry fields=0, out_valid=0 and in_ready=1.
REQ-029 SHALL take reset over flush; mid-transfer data is lost.
REQ-030 SHALL accept its first push on the first rising edge after reset deassertion.
REQ-031 SHALL present all outputs as 0 during reset, except in_ready=1.

Verification
REQ-032 SHALL cover: push instr 0x2402_0001/pc 0x3000 into empty, out_ready=1 -> next cycle out_valid=1, out_pc=0x3000; following cycle count=0, outputs 0.
REQ-033 SHALL cover: out_ready=0, push A(pc 0x3000), B(pc 0x3004), offer C -> count=2, in_ready=0, C not accepted; stall_cnt increments each stalled cycle.
REQ-034 SHALL cover: from count=2, raise out_ready one cycle -> A popped, count=1, in_ready=1, out_pc=0x3004.
REQ-035 SHALL cover: flush with count=2 and in_valid=1 -> next cycle count=1, out_instr=0, out_pc=0x0000_4180, out_exc=0, out_bd=0.
REQ-036 SHALL cover: assert reset asynchronously mid-cycle with count=2 and stall_cnt=7 -> count=0, stall_cnt=0, out_valid=0 before the next clock edge.
REQ-037 SHALL cover: hold out_valid=1, out_ready=0 for 65540 cycles -> stall_cnt=16'hFFFF with no wrap.
